// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: polls the UartRX status/data word, pushes each received byte
// into a small FIFO and presents a single CPU-visible status/data register.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_out,
  output logic        rx_clear,
  input  logic        sel,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out
);

  typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_HOLD} state_t;

  state_t        state, state_nxt;
  logic          push_req;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          ovf;

  logic cpu_wr, flush, pop_req, empty, full;
  logic do_pop, do_push, ovf_set;
  logic [2:0] cnt3;
  logic unused_bits;

  assign cpu_wr  = sel & load;
  assign flush   = cpu_wr & in[1];
  assign pop_req = cpu_wr & in[0];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // Flush overrides everything; a pop frees a slot so a push into a full FIFO fits.
  assign do_pop  = pop_req & ~empty & ~flush;
  assign do_push = push_req & ~flush & (~full | do_pop);
  assign ovf_set = push_req & ~flush & full & ~do_pop;

  // Only the valid flag, the byte and the two command bits are meaningful.
  assign unused_bits = ^{in[15:2], rx_out[14:8]};

  // Capture FSM state register; INIT on reset so rx_clear is high through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next state and outputs: one clear cycle, then one push per valid word.
  always_comb begin
    state_nxt = state;
    rx_clear  = 1'b0;
    push_req  = 1'b0;
    case (state)
      ST_INIT: begin
        rx_clear  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!rx_out[15]) begin
          push_req  = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rx_out[15]) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // FIFO storage; not reset since empty reads are masked at the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= rx_out[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // Low three count bits only; a full 8-deep FIFO therefore reads count 0.
  assign cnt3 = 3'(count);
  assign out  = {empty, ovf, 3'b000, cnt3, (empty ? 8'h00 : mem[rp])};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed vector table, async reset sequences and a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rx_out;
  logic        rx_clear;
  logic        sel;
  logic        load;
  logic [15:0] in_data;
  logic [15:0] out;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] q[$];
  logic       m_ovf;
  bit         m_init;
  bit         m_ready;

  typedef struct {
    logic [15:0] rx;
    logic        s;
    logic        l;
    logic [15:0] w;
    logic [15:0] exp_out;
    logic        exp_clr;
  } vec_t;

  vec_t tbl[$];

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset), .rx_out(rx_out), .rx_clear(rx_clear),
    .sel(sel), .load(load), .in(in_data), .out(out)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_init  = 1'b1;
    m_ready = 1'b0;
  endtask

  function automatic logic [15:0] model_out();
    int n = q.size();
    logic [7:0] h = (n == 0) ? 8'h00 : q[0];
    return {(n == 0), m_ovf, 3'b000, 3'(n), h};
  endfunction

  // One clock of the receiver's rules: the first cycle after reset is the
  // clear cycle; afterwards a valid word is taken once, and the receiver only
  // re-arms after seeing an idle word.
  task automatic model_step(input logic [15:0] rx, input logic s, input logic l, input logic [15:0] w);
    bit accept, pop_ok;
    accept = 0;
    if (m_init) begin
      m_init = 0; m_ready = 1;
    end else if (m_ready && !rx[15]) begin
      accept = 1; m_ready = 0;
    end else if (!m_ready && rx[15]) begin
      m_ready = 1;
    end
    if (s && l && w[1]) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop_ok = s && l && w[0] && (q.size() > 0);
      if (pop_ok) void'(q.pop_front());
      if (accept) begin
        if (q.size() < DEPTH) q.push_back(rx[7:0]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic [15:0] rx, input logic s, input logic l, input logic [15:0] w);
    rx_out = rx; sel = s; load = l; in_data = w;
    model_step(rx, s, l, w);
    @(posedge clk); #1;
    check("model_out", out, model_out());
    check("model_clr", {15'd0, rx_clear}, {15'd0, m_init});
  endtask

  task automatic add(input logic [15:0] rx, input logic s, input logic l, input logic [15:0] w,
                     input logic [15:0] eo, input logic ec);
    vec_t v;
    v.rx = rx; v.s = s; v.l = l; v.w = w; v.exp_out = eo; v.exp_clr = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] rxw;
    logic        s, l;
    logic [15:0] w;
    int r;

    reset = 1'b1; rx_out = 16'h8000; sel = 0; load = 0; in_data = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 16'h8000);
    check("rst_clr", {15'd0, rx_clear}, 16'd1);
    reset = 1'b0;
    #1;
    check("init_clr", {15'd0, rx_clear}, 16'd1);

    // idle after the clear cycle
    add(16'h8000, 0, 0, 16'h0, 16'h8000, 0);
    // single byte then pop
    add(16'h0041, 0, 0, 16'h0, 16'h0141, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h8000, 0);
    // held valid word pushes once
    for (int i = 0; i < 5; i++) add(16'h0055, 0, 0, 16'h0, 16'h0155, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0155, 0);
    add(16'h0066, 0, 0, 16'h0, 16'h0255, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h0166, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h8000, 0);
    // overflow: five bytes into four slots
    add(16'h0001, 0, 0, 16'h0, 16'h0101, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0101, 0);
    add(16'h0002, 0, 0, 16'h0, 16'h0201, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0201, 0);
    add(16'h0003, 0, 0, 16'h0, 16'h0301, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0301, 0);
    add(16'h0004, 0, 0, 16'h0, 16'h0401, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0401, 0);
    add(16'h0005, 0, 0, 16'h0, 16'h4401, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h4401, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h4302, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h4203, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h4104, 0);
    add(16'h8000, 1, 1, 16'h1, 16'hC000, 0);
    add(16'h8000, 1, 1, 16'h1, 16'hC000, 0);  // pop when empty ignored
    // flush clears overflow
    add(16'h8000, 1, 1, 16'h2, 16'h8000, 0);
    // fill to full, then push and pop together
    add(16'h0011, 0, 0, 16'h0, 16'h0111, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0111, 0);
    add(16'h0022, 0, 0, 16'h0, 16'h0211, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0211, 0);
    add(16'h0033, 0, 0, 16'h0, 16'h0311, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0311, 0);
    add(16'h0044, 0, 0, 16'h0, 16'h0411, 0);
    add(16'h8000, 0, 1, 16'h3, 16'h0411, 0);  // load without sel ignored
    add(16'h00AA, 1, 1, 16'h1, 16'h0422, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h0422, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h0333, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h0244, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h01AA, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h8000, 0);
    // push on empty with pop: push only
    add(16'h0039, 1, 1, 16'h1, 16'h0139, 0);
    add(16'h8000, 1, 1, 16'h1, 16'h8000, 0);
    // flush beats a same-cycle push
    add(16'h0077, 1, 1, 16'h2, 16'h8000, 0);
    add(16'h8000, 0, 0, 16'h0, 16'h8000, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rx, tbl[i].s, tbl[i].l, tbl[i].w);
      check($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      check($sformatf("tbl%0d_clr", i), {15'd0, rx_clear}, {15'd0, tbl[i].exp_clr});
    end

    // reset asserted mid-HOLD takes effect without a clock edge
    cycle(16'h0012, 0, 0, 16'h0);
    #5 reset = 1'b1;
    #1;
    check("async_out", out, 16'h8000);
    check("async_clr", {15'd0, rx_clear}, 16'd1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reinit_clr", {15'd0, rx_clear}, 16'd1);
    cycle(16'h0012, 0, 0, 16'h0);  // ignored during the clear cycle
    check("reinit_ignore", out, 16'h8000);
    cycle(16'h0012, 0, 0, 16'h0);
    check("reinit_push", out, 16'h0112);

    // randomized traffic against the model
    rxw = 16'h8000;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rxw = {1'b1, 15'($urandom)};
      else if (r < 7) rxw = rxw;
      else            rxw = {1'b0, 15'($urandom)};
      s = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      w = {14'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0)};
      cycle(rxw, s, l, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
